// File: rtl/ili9341_frame_streamer.sv
// ili9341_frame_streamer
// Produces the per-frame ILI9341 command stream on the fly: a column/page
// window header followed by every RGB565 pixel as two data bytes. Each output
// word is {cs, dc, byte}. Words leave through a registered valid/ready slot,
// and pixels arrive over a second valid/ready handshake.
module ili9341_frame_streamer #(
    parameter int unsigned WIDTH  = 240,
    parameter int unsigned HEIGHT = 320,
    localparam int unsigned PIXW  = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [9:0]  cmd_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0]     XE       = 16'(WIDTH - 32'd1);
    localparam logic [15:0]     YE       = 16'(HEIGHT - 32'd1);
    localparam logic [PIXW-1:0] PIX_LAST = PIXW'(WIDTH * HEIGHT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_PIX_HI = 3'd2,
        S_PIX_LO = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [9:0]      cmd_word_r, word_nxt_s;
    logic            cmd_valid_r, valid_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            frame_done_r, done_nxt_s;
    logic [3:0]      hdr_idx_r;
    logic [PIXW-1:0] pix_cnt_r;
    logic [7:0]      lo_byte_r;
    logic            slot_free_s;
    logic            pix_ready_s;
    logic            clear_s, hdr_inc_s, lo_latch_s, cnt_inc_s;

    // Window header: CASET with XS=0/XE, PASET with YS=0/YE, then RAMWR.
    function automatic logic [9:0] hdr_word(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_word = 10'h02A;
            4'd1:    hdr_word = 10'h100;
            4'd2:    hdr_word = 10'h100;
            4'd3:    hdr_word = {2'b01, XE[15:8]};
            4'd4:    hdr_word = {2'b01, XE[7:0]};
            4'd5:    hdr_word = 10'h02B;
            4'd6:    hdr_word = 10'h100;
            4'd7:    hdr_word = 10'h100;
            4'd8:    hdr_word = {2'b01, YE[15:8]};
            4'd9:    hdr_word = {2'b01, YE[7:0]};
            4'd10:   hdr_word = 10'h02C;
            default: hdr_word = 10'h000;
        endcase
    endfunction

    // The output slot can take a new word when empty or being drained now.
    assign slot_free_s = !cmd_valid_r || cmd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_HDR;
                else       state_nxt_s = S_IDLE;
            end
            S_HDR: begin
                if (slot_free_s && (hdr_idx_r == 4'd10)) state_nxt_s = S_PIX_HI;
                else                                     state_nxt_s = S_HDR;
            end
            S_PIX_HI: begin
                if (slot_free_s && pix_valid) state_nxt_s = S_PIX_LO;
                else                          state_nxt_s = S_PIX_HI;
            end
            S_PIX_LO: begin
                if (!slot_free_s)                state_nxt_s = S_PIX_LO;
                else if (pix_cnt_r == PIX_LAST)  state_nxt_s = S_FIN;
                else                             state_nxt_s = S_PIX_HI;
            end
            S_FIN: begin
                if (cmd_valid_r && cmd_ready) state_nxt_s = S_IDLE;
                else                          state_nxt_s = S_FIN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Per-state datapath controls; an unrefilled slot drains to empty.
    always_comb begin
        pix_ready_s = 1'b0;
        word_nxt_s  = cmd_word_r;
        valid_nxt_s = cmd_valid_r && !cmd_ready;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        clear_s     = 1'b0;
        hdr_inc_s   = 1'b0;
        lo_latch_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_nxt_s = 1'b1;
                    clear_s    = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            S_HDR: begin
                if (slot_free_s) begin
                    word_nxt_s  = hdr_word(hdr_idx_r);
                    valid_nxt_s = 1'b1;
                    hdr_inc_s   = 1'b1;
                end else begin
                    hdr_inc_s = 1'b0;
                end
            end
            S_PIX_HI: begin
                pix_ready_s = slot_free_s;
                if (slot_free_s && pix_valid) begin
                    word_nxt_s  = {2'b01, pix_data[15:8]};
                    valid_nxt_s = 1'b1;
                    lo_latch_s  = 1'b1;
                end else begin
                    lo_latch_s = 1'b0;
                end
            end
            S_PIX_LO: begin
                if (slot_free_s) begin
                    word_nxt_s  = {2'b01, lo_byte_r};
                    valid_nxt_s = 1'b1;
                    cnt_inc_s   = 1'b1;
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            S_FIN: begin
                if (cmd_valid_r && cmd_ready) begin
                    done_nxt_s = 1'b1;
                    busy_nxt_s = 1'b0;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Output slot, status flags, header index, pixel counter and low-byte latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_word_r   <= 10'h000;
            cmd_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            hdr_idx_r    <= 4'd0;
            pix_cnt_r    <= '0;
            lo_byte_r    <= 8'h00;
        end else begin
            cmd_word_r   <= word_nxt_s;
            cmd_valid_r  <= valid_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= done_nxt_s;
            if (clear_s)        hdr_idx_r <= 4'd0;
            else if (hdr_inc_s) hdr_idx_r <= hdr_idx_r + 4'd1;
            else                hdr_idx_r <= hdr_idx_r;
            if (clear_s)        pix_cnt_r <= '0;
            else if (cnt_inc_s) pix_cnt_r <= pix_cnt_r + {{(PIXW-1){1'b0}}, 1'b1};
            else                pix_cnt_r <= pix_cnt_r;
            if (lo_latch_s)     lo_byte_r <= pix_data[7:0];
            else                lo_byte_r <= lo_byte_r;
        end
    end

    assign cmd_word   = cmd_word_r;
    assign cmd_valid  = cmd_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign pix_ready  = pix_ready_s;

endmodule

// File: tb/tb_ili9341_frame_streamer.sv
// Directed bench for ili9341_frame_streamer: a 2x2 instance exercises the full
// frame sequence, stalls, pixel gaps, ignored start and mid-frame reset; a
// default-size instance checks the header window bytes.
module tb_ili9341_frame_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2x2 instance
    logic        s_rst, s_start, s_pix_valid, s_pix_ready;
    logic [15:0] s_pix_data;
    logic [9:0]  s_cmd_word;
    logic        s_cmd_valid, s_cmd_ready, s_busy, s_frame_done;

    // default-size instance
    logic        d_rst, d_start, d_pix_ready;
    logic [9:0]  d_cmd_word;
    logic        d_cmd_valid, d_busy, d_frame_done;

    ili9341_frame_streamer #(.WIDTH(2), .HEIGHT(2)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start),
        .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .cmd_word(s_cmd_word), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .busy(s_busy), .frame_done(s_frame_done)
    );

    ili9341_frame_streamer u_dflt (
        .clk(clk), .rst(d_rst), .start(d_start),
        .pix_data(16'h5A5A), .pix_valid(1'b1), .pix_ready(d_pix_ready),
        .cmd_word(d_cmd_word), .cmd_valid(d_cmd_valid), .cmd_ready(1'b1),
        .busy(d_busy), .frame_done(d_frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [9:0] exp_seq [19] = '{10'h02A, 10'h100, 10'h100, 10'h100, 10'h101,
                                 10'h02B, 10'h100, 10'h100, 10'h100, 10'h101,
                                 10'h02C, 10'h1CB, 10'h138, 10'h112, 10'h134,
                                 10'h1AB, 10'h1CD, 10'h100, 10'h101};
    logic [9:0] exp_dflt [11] = '{10'h02A, 10'h100, 10'h100, 10'h100, 10'h1EF,
                                  10'h02B, 10'h100, 10'h100, 10'h101, 10'h13F,
                                  10'h02C};

    // pixel source: four fixed pixels, advanced on each pixel handshake
    logic [1:0] pix_idx;
    function automatic logic [15:0] pix_tab(input logic [1:0] i);
        case (i)
            2'd0:    pix_tab = 16'hCB38;
            2'd1:    pix_tab = 16'h1234;
            2'd2:    pix_tab = 16'hABCD;
            default: pix_tab = 16'h0001;
        endcase
    endfunction
    assign s_pix_data = pix_tab(pix_idx);

    // advance the pixel pointer on every accepted pixel
    always @(posedge clk) begin
        if (s_rst) pix_idx <= 2'd0;
        else if (s_pix_valid && s_pix_ready) pix_idx <= pix_idx + 2'd1;
    end

    // monitor state (written only by the monitors)
    logic [9:0] sq[$];
    logic [9:0] dq[$];
    int done_cnt = 0, busy_cnt = 0, bubble_cnt = 0, cs_err = 0;
    int hold_samples = 0, hold_viol = 0, gap_samples = 0, gap_err = 0;
    logic       held_valid = 1'b0;
    logic [9:0] held_word  = 10'h000;

    // observe the 2x2 instance away from the active edge
    always @(negedge clk) begin
        if (!s_rst) begin
            if (s_cmd_valid && s_cmd_ready) sq.push_back(s_cmd_word);
            if (s_frame_done) done_cnt <= done_cnt + 1;
            if (s_busy) busy_cnt <= busy_cnt + 1;
            if (s_busy && !s_cmd_valid) bubble_cnt <= bubble_cnt + 1;
            if (s_cmd_valid && s_cmd_word[9]) cs_err <= cs_err + 1;
            if (held_valid) begin
                hold_samples <= hold_samples + 1;
                if (!s_cmd_valid || (s_cmd_word !== held_word)) hold_viol <= hold_viol + 1;
            end
            held_valid <= s_cmd_valid && !s_cmd_ready;
            held_word  <= s_cmd_word;
            if (s_busy && !s_pix_valid && !s_cmd_valid) begin
                gap_samples <= gap_samples + 1;
                if (!s_pix_ready) gap_err <= gap_err + 1;
            end
        end else begin
            held_valid <= 1'b0;
        end
    end

    // collect words from the default-size instance
    always @(negedge clk) begin
        if (!d_rst && d_cmd_valid) dq.push_back(d_cmd_word);
    end

    // start a frame on the 2x2 instance and drive it until frame_done or abort
    task automatic run_frame(input string tag, input bit rand_ready, input int gap_len,
                             input bit extra_start, input int abort_words);
        int base = sq.size();
        int gap_left = gap_len;
        int cyc = 0;
        @(posedge clk); #1;
        s_start     = 1'b1;
        s_pix_valid = 1'b1;
        s_cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cyc < 400) begin
            @(posedge clk); #1;
            if (s_frame_done) break;
            if (abort_words > 0 && (sq.size() - base) >= abort_words) break;
            s_start     = extra_start && (cyc == 4);
            s_cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gap_left > 0 && pix_idx == 2'd1) begin
                s_pix_valid = 1'b0;
                gap_left--;
            end else begin
                s_pix_valid = 1'b1;
            end
            cyc++;
        end
        check_value({tag, "_in_time"}, 32'(cyc < 400), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        check_value({tag, "_count"}, 32'(sq.size() - base), 32'd19);
        for (int i = 0; i < 19; i++) begin
            check_value($sformatf("%s_w%0d", tag, i), 32'(sq[base + i]), 32'(exp_seq[i]));
        end
    endtask

    int b_q, b_done, b_busy, b_bub, b_gap, b_gerr;

    task automatic snap();
        b_q = sq.size(); b_done = done_cnt; b_busy = busy_cnt;
        b_bub = bubble_cnt; b_gap = gap_samples; b_gerr = gap_err;
    endtask

    initial begin
        s_rst = 1'b1; s_start = 1'b0; s_pix_valid = 1'b1; s_cmd_ready = 1'b1;
        d_rst = 1'b1; d_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_rst = 1'b0; d_rst = 1'b0;
        @(negedge clk);
        check_value("rst_word",  32'(s_cmd_word),   32'h000);
        check_value("rst_valid", 32'(s_cmd_valid),  32'd0);
        check_value("rst_pixrdy", 32'(s_pix_ready), 32'd0);
        check_value("rst_busy",  32'(s_busy),       32'd0);
        check_value("rst_done",  32'(s_frame_done), 32'd0);

        // default-size header window
        @(posedge clk); #1; d_start = 1'b1;
        @(posedge clk); #1; d_start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_value("dflt_busy", 32'(d_busy), 32'd1);
        check_value("dflt_nodone", 32'(d_frame_done), 32'd0);
        check_value("dflt_count_ge11", 32'(dq.size() >= 11), 32'd1);
        for (int i = 0; i < 11; i++) begin
            check_value($sformatf("dflt_hdr%0d", i), 32'(dq[i]), 32'(exp_dflt[i]));
        end
        d_rst = 1'b1;
        @(posedge clk); #1;
        check_value("dflt_rst_busy", 32'(d_busy), 32'd0);
        check_value("dflt_rst_pixrdy", 32'(d_pix_ready), 32'd0);

        // 1: full-rate frame
        snap();
        run_frame("s1", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        check_seq("s1", b_q);
        check_value("s1_done", 32'(done_cnt - b_done), 32'd1);
        check_value("s1_busy_cycles", 32'(busy_cnt - b_busy), 32'd20);
        check_value("s1_bubbles", 32'(bubble_cnt - b_bub), 32'd1);

        // 3: random backpressure
        snap();
        run_frame("s3", 1'b1, 0, 1'b0, 0);
        @(posedge clk); #1;
        s_cmd_ready = 1'b1;
        check_seq("s3", b_q);
        check_value("s3_done", 32'(done_cnt - b_done), 32'd1);
        check_value("s3_stalled", 32'(hold_samples > 0), 32'd1);
        check_value("s3_hold_stable", 32'(hold_viol), 32'd0);

        // 4: five-cycle pixel gap before pixel 2
        snap();
        run_frame("s4", 1'b0, 5, 1'b0, 0);
        @(posedge clk); #1;
        check_seq("s4", b_q);
        check_value("s4_busy_cycles", 32'(busy_cnt - b_busy), 32'd24);
        check_value("s4_bubbles", 32'(bubble_cnt - b_bub), 32'd5);
        check_value("s4_gap_samples", 32'(gap_samples - b_gap), 32'd3);
        check_value("s4_gap_pixrdy", 32'(gap_err - b_gerr), 32'd0);

        // 5: start during header ignored; a later start gives an identical frame
        snap();
        run_frame("s5a", 1'b0, 0, 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        check_seq("s5a", b_q);
        check_value("s5_single_done", 32'(done_cnt - b_done), 32'd1);
        check_value("s5_idle_busy", 32'(s_busy), 32'd0);
        snap();
        run_frame("s5b", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        check_seq("s5b", b_q);

        // 6: reset right after 0x1CB is accepted
        snap();
        run_frame("s6a", 1'b0, 0, 1'b0, 12);
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        check_value("s6_rst_valid", 32'(s_cmd_valid), 32'd0);
        check_value("s6_rst_busy", 32'(s_busy), 32'd0);
        check_value("s6_rst_pixrdy", 32'(s_pix_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_value("s6_no_done", 32'(done_cnt - b_done), 32'd0);
        check_value("s6_partial_words", 32'(sq.size() - b_q), 32'd12);
        snap();
        run_frame("s6b", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        check_seq("s6b", b_q);
        check_value("s6_done", 32'(done_cnt - b_done), 32'd1);

        check_value("cs_low", 32'(cs_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
